// File: rtl/cell_window_scanner.sv
// Scans a COLS x ROWS bit map in row-major order and emits each cell's 3x3 neighbourhood with its coordinates.
// Latency: 10 fetch cycles per cell plus one emit cycle; first window is valid 11 cycles after start is sampled.
// Backpressure: the window and coordinates hold in EMIT until win_ready; no map reads are issued while stalled.
module cell_window_scanner #(
    parameter int COLS   = 16,
    parameter int ROWS   = 12,
    parameter int X_W    = 4,
    parameter int Y_W    = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    output logic [8:0]        win,
    output logic [X_W-1:0]    win_x,
    output logic [Y_W-1:0]    win_y,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [3:0]      k;
    logic            last_x;
    logic            last_y;
    logic [X_W-1:0]  nx;
    logic [Y_W-1:0]  ny;

    // True when neighbour kk of cell (cx, cy) lies inside the map.
    function automatic logic nb_in(input logic [X_W-1:0] cx, input logic [Y_W-1:0] cy,
                                   input logic [3:0] kk);
        int tx;
        int ty;
        tx = int'(cx) + int'(kk) % 3 - 1;
        ty = int'(cy) + int'(kk) / 3 - 1;
        return (tx >= 0) && (tx < COLS) && (ty >= 0) && (ty < ROWS);
    endfunction

    // RAM address of neighbour kk of cell (cx, cy); zero when off the map.
    function automatic logic [ADDR_W-1:0] nb_addr(input logic [X_W-1:0] cx,
                                                  input logic [Y_W-1:0] cy,
                                                  input logic [3:0] kk);
        int tx;
        int ty;
        tx = int'(cx) + int'(kk) % 3 - 1;
        ty = int'(cy) + int'(kk) / 3 - 1;
        if ((tx >= 0) && (tx < COLS) && (ty >= 0) && (ty < ROWS))
            return ADDR_W'(ty * COLS + tx);
        else
            return '0;
    endfunction

    // Coordinates of the next cell in row-major order.
    always_comb begin
        last_x = (x == X_W'(COLS - 1));
        last_y = (y == Y_W'(ROWS - 1));
        nx     = last_x ? '0 : x + 1'b1;
        ny     = last_x ? y + 1'b1 : y;
    end

    assign win_x = x;
    assign win_y = y;

    // Scan FSM: issue reads one neighbour per cycle, capture each bit one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            x         <= '0;
            y         <= '0;
            k         <= '0;
            win       <= '0;
            win_valid <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= S_FETCH;
                        x       <= '0;
                        y       <= '0;
                        k       <= '0;
                        busy    <= 1'b1;
                        rd_en   <= nb_in('0, '0, 4'd0);
                        rd_addr <= nb_addr('0, '0, 4'd0);
                    end
                end
                S_FETCH: begin
                    // Data for neighbour k-1 arrives while the counter reads k.
                    if (k != 4'd0)
                        win[k - 4'd1] <= nb_in(x, y, k - 4'd1) ? rd_data : 1'b0;
                    if (k == 4'd9) begin
                        state     <= S_EMIT;
                        win_valid <= 1'b1;
                        rd_en     <= 1'b0;
                        rd_addr   <= '0;
                    end else begin
                        k <= k + 4'd1;
                        if (k < 4'd8) begin
                            rd_en   <= nb_in(x, y, k + 4'd1);
                            rd_addr <= nb_addr(x, y, k + 4'd1);
                        end else begin
                            rd_en   <= 1'b0;
                            rd_addr <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (last_x && last_y) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_FETCH;
                            x       <= nx;
                            y       <= ny;
                            k       <= '0;
                            rd_en   <= nb_in(nx, ny, 4'd0);
                            rd_addr <= nb_addr(nx, ny, 4'd0);
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
